// File: rtl/emulador_de_teclado_pkg.sv
// Shared definitions for the 4x4 keypad emulator/decoder pair: key map,
// code <-> (row,col) conversion and the emulator state type.
package teclado_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOUNCE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } estado_emul_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rowcol_t;

    // Indexed by {row, col}; every hex code appears exactly once
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hF, 4'h0, 4'hE, 4'hD
    };

    localparam int HOLD_CYCLES_DEF    = 140;
    localparam int BOUNCE_PERIOD_DEF  = 8;
    localparam int BOUNCE_TOGGLES_DEF = 6;
    localparam int RELEASE_CYCLES_DEF = 140;
    localparam int CNT_W_DEF          = 8;

    function automatic rowcol_t key_to_rowcol(input logic [3:0] code);
        rowcol_t rc;
        rc = '0;
        for (int i = 0; i < 16; i++) begin
            if (KEY_MAP[i] == code) begin
                rc = rowcol_t'(4'(i));
            end else begin
                rc = rc;
            end
        end
        return rc;
    endfunction

    function automatic logic [3:0] rowcol_to_key(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/emulador_de_teclado_if.sv
// Command handshake and status bundle between a key-request source and the
// keypad emulator.
interface emulador_de_teclado_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic       cmd_bounce;
    logic       cancel;
    logic       busy;
    logic       done;

    modport master (
        output cmd_valid, cmd_key, cmd_bounce, cancel,
        input  cmd_ready, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_key, cmd_bounce, cancel,
        output cmd_ready, busy, done
    );
endinterface

// File: rtl/emulador_de_teclado.sv
// 4x4 matrix-keypad switch emulator: presses the requested key (optionally
// bouncing), holds it, releases it and pulses done.
module emulador_de_teclado
    import teclado_pkg::*;
#(
    parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int BOUNCE_PERIOD  = BOUNCE_PERIOD_DEF,
    parameter int BOUNCE_TOGGLES = BOUNCE_TOGGLES_DEF,
    parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             lin_matriz,
    output logic [3:0]             col_matriz,
    emulador_de_teclado_if.slave   cmd
);

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD  = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] TOGGLE_LOAD  = CNT_W'(BOUNCE_TOGGLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    estado_emul_t     state_r;
    estado_emul_t     state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] tog_r;
    logic             contato_r;
    logic [1:0]       row_r;
    logic [1:0]       col_r;
    logic             done_r;
    rowcol_t          key_rc_s;
    logic             cnt_zero_s;

    assign key_rc_s   = key_to_rowcol(cmd.cmd_key);
    assign cnt_zero_s = (cnt_r == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; cancel outranks phase completion
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_s = cmd.cmd_bounce ? BOUNCE : HOLD;
                end else begin
                    state_s = IDLE;
                end
            end
            BOUNCE: begin
                if (cmd.cancel) begin
                    state_s = RELEASE;
                end else if (cnt_zero_s && (tog_r == '0)) begin
                    state_s = HOLD;
                end else begin
                    state_s = BOUNCE;
                end
            end
            HOLD: begin
                if (cmd.cancel || cnt_zero_s) begin
                    state_s = RELEASE;
                end else begin
                    state_s = HOLD;
                end
            end
            RELEASE: begin
                if (cnt_zero_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Counters, contact level, latched key position and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            tog_r     <= '0;
            contato_r <= 1'b0;
            row_r     <= 2'd0;
            col_r     <= 2'd0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == RELEASE) && cnt_zero_s;
            case (state_r)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        row_r     <= key_rc_s.row;
                        col_r     <= key_rc_s.col;
                        contato_r <= 1'b1;
                        cnt_r     <= cmd.cmd_bounce ? PERIOD_LOAD : HOLD_LOAD;
                        tog_r     <= TOGGLE_LOAD;
                    end else begin
                        contato_r <= 1'b0;
                    end
                end
                BOUNCE: begin
                    if (cmd.cancel) begin
                        contato_r <= 1'b0;
                        cnt_r     <= RELEASE_LOAD;
                    end else if (cnt_zero_s) begin
                        // An even toggle count leaves the contact closed entering HOLD
                        contato_r <= ~contato_r;
                        if (tog_r == '0) begin
                            cnt_r <= HOLD_LOAD;
                        end else begin
                            cnt_r <= PERIOD_LOAD;
                            tog_r <= tog_r - CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cmd.cancel || cnt_zero_s) begin
                        contato_r <= 1'b0;
                        cnt_r     <= RELEASE_LOAD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    contato_r <= 1'b0;
                    cnt_r     <= '0;
                end
            endcase
        end
    end

    // Switch model: column follows the latched row drive with no delay
    always_comb begin
        col_matriz    = 4'b1111;
        cmd.cmd_ready = (state_r == IDLE);
        cmd.busy      = (state_r != IDLE);
        cmd.done      = done_r;
        if (contato_r && !lin_matriz[row_r]) begin
            col_matriz = ~(4'b0001 << col_r);
        end else begin
            col_matriz = 4'b1111;
        end
    end

endmodule

// File: tb/tb_emulador_de_teclado.sv
// Randomized scoreboard bench for emulador_de_teclado: commands queue their
// expected press profile, a negedge monitor checks the switch and status lines.
module tb_emulador_de_teclado;

    localparam int P = 8;
    localparam int T = 6;
    localparam int H = 140;
    localparam int R = 140;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lin_matriz;
    logic [3:0] col_matriz;

    emulador_de_teclado_if cmd_if();

    emulador_de_teclado #(
        .HOLD_CYCLES(H), .BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(T),
        .RELEASE_CYCLES(R), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lin_matriz (lin_matriz),
        .col_matriz (col_matriz),
        .cmd        (cmd_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] key;
        bit         bounce;
        int         cancel_at;
    } cmd_t;

    // Keypad layout as printed on the keys: KM[row][col]
    localparam logic [3:0] KM [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hF, 4'h0, 4'hE, 4'hD}
    };

    cmd_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   printed = 0;

    function automatic void find_rc(input logic [3:0] key, output int r, output int c);
        r = 0; c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (KM[i][j] == key) begin r = i; c = j; end
    endfunction

    function automatic int bounce_len(input cmd_t c);
        return c.bounce ? T * P : 0;
    endfunction

    // Cycle (counted from the first cycle after transfer) where release begins
    function automatic int rel_start(input cmd_t c);
        int nat;
        nat = bounce_len(c) + H;
        return (c.cancel_at >= 0 && c.cancel_at < nat) ? c.cancel_at + 1 : nat;
    endfunction

    function automatic int done_k(input cmd_t c);
        return rel_start(c) + R;
    endfunction

    function automatic bit contact(input cmd_t c, input int k);
        if (k < 0 || k >= rel_start(c)) return 1'b0;
        if (k >= bounce_len(c)) return 1'b1;
        return ((k / P) % 2) == 0;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            miscompares++;
            if (printed < 30) begin
                printed++;
                $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
            end
        end
    endtask

    bit   active = 1'b0;
    int   k = 0;
    cmd_t cur;

    // Monitor: replays the queued command's press profile and compares every cycle
    always @(negedge clk) begin
        logic [3:0] e_col;
        logic [3:0] one;
        bit         e_busy, e_done;
        int         r, c, dk;
        if (rst) begin
            active = 1'b0;
            exp_q.delete();
        end else begin
            e_col = 4'hF; e_busy = 1'b0; e_done = 1'b0; dk = 0; one = 4'b0001;
            if (active) begin
                k++;
                dk = done_k(cur);
                find_rc(cur.key, r, c);
                if (contact(cur, k) && !lin_matriz[r]) e_col = ~(one << c);
                e_busy = (k < dk);
                e_done = (k == dk);
            end
            vectors++;
            check("col_matriz", col_matriz, e_col);
            check("busy", {3'b000, cmd_if.busy}, {3'b000, e_busy});
            check("cmd_ready", {3'b000, cmd_if.cmd_ready}, {3'b000, !e_busy});
            check("done", {3'b000, cmd_if.done}, {3'b000, e_done});
            if (active && k == dk) begin
                void'(exp_q.pop_front());
                active = 1'b0;
            end
            if (!active && exp_q.size() > 0 && cmd_if.cmd_valid) begin
                cur    = exp_q[0];
                k      = -1;
                active = 1'b1;
            end
        end
    end

    task automatic drive_lin(input logic [3:0] key);
        int r, c;
        logic [3:0] one;
        one = 4'b0001;
        find_rc(key, r, c);
        case ($urandom_range(0, 3))
            0, 1:    lin_matriz = ~(one << r);
            2:       lin_matriz = 4'($urandom);
            default: lin_matriz = ~(one << ((r + 1) % 4));
        endcase
    endtask

    task automatic run_cmd(input logic [3:0] key, input bit bounce, input int cancel_at, input bit noise);
        cmd_t c;
        int   dk, rs;
        c  = '{key: key, bounce: bounce, cancel_at: cancel_at};
        dk = done_k(c);
        rs = rel_start(c);
        exp_q.push_back(c);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_key    = key;
        cmd_if.cmd_bounce = bounce;
        cmd_if.cancel     = 1'($urandom_range(0, 1));
        drive_lin(key);
        @(posedge clk); #1;
        for (int i = 0; i < dk; i++) begin
            cmd_if.cancel = (i == cancel_at) || (i >= rs && i < dk - 1 && $urandom_range(0, 7) == 0);
            if (noise && i < dk - 1) begin
                cmd_if.cmd_valid  = 1'($urandom_range(0, 1));
                cmd_if.cmd_key    = 4'($urandom);
                cmd_if.cmd_bounce = 1'($urandom_range(0, 1));
            end else begin
                cmd_if.cmd_valid = 1'b0;
            end
            drive_lin(key);
            @(posedge clk); #1;
        end
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cancel    = 1'b0;
    endtask

    task automatic idle(input int n);
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            cmd_if.cancel = 1'b0;
            lin_matriz    = 4'($urandom);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [3:0] key;
        bit         bnc;
        int         cat;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_key = 4'h0;
        cmd_if.cmd_bounce = 1'b0; cmd_if.cancel = 1'b0;
        lin_matriz = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        run_cmd(4'h5, 1'b0, -1, 1'b0);
        idle(1);
        run_cmd(4'hA, 1'b1, -1, 1'b0);
        run_cmd(4'h0, 1'b0, 20, 1'b0);
        run_cmd(4'h8, 1'b0, -1, 1'b1);
        run_cmd(4'hE, 1'b1, 13, 1'b0);

        for (int n = 0; n < 30; n++) begin
            key = 4'($urandom);
            bnc = 1'($urandom_range(0, 1));
            cat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (bnc ? T * P : 0) + H - 1) : -1;
            run_cmd(key, bnc, cat, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end

        // Reset in the middle of a held 0xD, then a fresh 0x3
        exp_q.push_back('{key: 4'hD, bounce: 1'b0, cancel_at: -1});
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_key = 4'hD; cmd_if.cmd_bounce = 1'b0;
        lin_matriz = 4'b0111;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lin_matriz = 4'b0111;
        @(posedge clk); #1;
        run_cmd(4'h3, 1'b0, -1, 1'b0);
        idle(4);

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d commands left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
